// File: rtl/mux_pkg.sv
// Shared types and helpers for the mux_nx1_scan slice.
// MUX_CH_MASK_EN enables the per-channel mask search helper.
package mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_e;

    localparam int DWELL_W = 8;
    localparam int MAX_CH  = 64;

`ifdef MUX_CH_MASK_EN
    // Returns {passed_last, index} of the next enabled channel above cur, wrapping through 0.
    function automatic logic [6:0] next_unmasked(
        input logic [MAX_CH-1:0] mask,
        input logic [5:0]        cur,
        input int                n_ch
    );
        logic [6:0] res;
        logic       found;
        int         cand;
        int         idx;
        res   = {1'b0, cur};
        found = 1'b0;
        for (int step = 1; step <= MAX_CH; step++) begin
            cand = int'(cur) + step;
            idx  = (cand >= n_ch) ? cand - n_ch : cand;
            if (!found && step <= n_ch && mask[idx]) begin
                found = 1'b1;
                res   = {(cand >= n_ch), 6'(idx)};
            end
        end
        return res;
    endfunction
`endif

endpackage

// File: rtl/mux_scan_ctr.sv
// Dwell counter and round-robin channel stepping for scan mode, including the wrap pulse.
// MUX_CH_MASK_EN adds skipping of masked channels.
module mux_scan_ctr
    import mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int SEL_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               scan_run,
    input  logic               scan_start,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [SEL_W-1:0]   cur_ch,
`ifdef MUX_CH_MASK_EN
    input  logic [N_CH-1:0]    ch_mask,
`endif
    output logic [SEL_W-1:0]   next_ch,
    output logic               ch_ok,
    output logic               wrap
);

    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               wrap_q, wrap_d;
    logic [DWELL_W-1:0] last_cnt;
    logic               advance;

    // A dwell of 0 behaves as 1; >= lets a shortened dwell advance at once.
    always_comb begin
        last_cnt = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
        advance  = (cnt_q >= last_cnt);
    end

`ifdef MUX_CH_MASK_EN
    logic       mask_any;
    logic [6:0] first_hit;
    logic [6:0] next_hit;

    always_comb begin
        mask_any  = |ch_mask;
        first_hit = next_unmasked(64'(ch_mask), 6'(N_CH - 1), N_CH);
        next_hit  = next_unmasked(64'(ch_mask), 6'(cur_ch), N_CH);
        next_ch   = cur_ch;
        cnt_d     = cnt_q;
        wrap_d    = 1'b0;
        if (!scan_run) begin
            cnt_d = '0;
        end else if (!mask_any) begin
            next_ch = cur_ch;
        end else if (scan_start) begin
            next_ch = first_hit[SEL_W-1:0];
            cnt_d   = '0;
        end else if (advance) begin
            next_ch = next_hit[SEL_W-1:0];
            wrap_d  = next_hit[6];
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + DWELL_W'(1);
        end
        ch_ok = mask_any && ch_mask[next_ch];
    end
`else
    always_comb begin
        next_ch = cur_ch;
        ch_ok   = 1'b1;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        if (!scan_run) begin
            cnt_d = '0;
        end else if (scan_start) begin
            next_ch = '0;
            cnt_d   = '0;
        end else if (advance) begin
            cnt_d = '0;
            if (int'(cur_ch) >= N_CH - 1) begin
                next_ch = '0;
                wrap_d  = 1'b1;
            end else begin
                next_ch = cur_ch + SEL_W'(1);
            end
        end else begin
            cnt_d = cnt_q + DWELL_W'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;

endmodule

// File: rtl/mux_nx1_scan.sv
// Registered N:1 mux with manual select and round-robin auto-scan modes.
// Define MUX_CH_MASK_EN to add the ch_mask channel-enable input.
module mux_nx1_scan
    import mux_pkg::*;
#(
    parameter  int N_CH   = 4,
    parameter  int DATA_W = 1,
    localparam int SEL_W  = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [DWELL_W-1:0]       dwell,
    input  logic [N_CH*DATA_W-1:0]   a,
`ifdef MUX_CH_MASK_EN
    input  logic [N_CH-1:0]          ch_mask,
`endif
    output logic [DATA_W-1:0]        y,
    output logic                     y_valid,
    output logic [SEL_W-1:0]         cur_ch,
    output logic                     wrap
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   y_q, y_d;
    logic                y_valid_q, y_valid_d;
    logic [SEL_W-1:0]    cur_ch_q, cur_ch_d;
    logic [SEL_W-1:0]    scan_ch;
    logic                scan_ok;
    logic                sel_ok;

    function automatic logic [DATA_W-1:0] chan_data(
        input logic [N_CH*DATA_W-1:0] bus,
        input logic [SEL_W-1:0]       idx
    );
        logic [DATA_W-1:0] r;
        r = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (int'(idx) == k) r = bus[k*DATA_W +: DATA_W];
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = IDLE;
        if (enable) state_d = mode ? SCAN : MANUAL;
    end

    mux_scan_ctr #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_scan_ctr (
        .clk        (clk),
        .rst        (rst),
        .scan_run   (state_d == SCAN),
        .scan_start (state_q != SCAN),
        .dwell      (dwell),
        .cur_ch     (cur_ch_q),
`ifdef MUX_CH_MASK_EN
        .ch_mask    (ch_mask),
`endif
        .next_ch    (scan_ch),
        .ch_ok      (scan_ok),
        .wrap       (wrap)
    );

    // Outputs are computed for the state being entered at this edge.
    always_comb begin
`ifdef MUX_CH_MASK_EN
        sel_ok = (int'(sel) < N_CH) && ch_mask[sel];
`else
        sel_ok = (int'(sel) < N_CH);
`endif
        y_d       = '0;
        y_valid_d = 1'b0;
        cur_ch_d  = cur_ch_q;
        unique case (state_d)
            MANUAL: begin
                cur_ch_d = sel;
                if (sel_ok) begin
                    y_d       = chan_data(a, sel);
                    y_valid_d = 1'b1;
                end
            end
            SCAN: begin
                cur_ch_d = scan_ch;
                if (scan_ok) begin
                    y_d       = chan_data(a, scan_ch);
                    y_valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
            cur_ch_q  <= '0;
        end else begin
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            cur_ch_q  <= cur_ch_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign cur_ch  = cur_ch_q;

endmodule
